// File: rtl/g256_out_stage_2om_pkg.sv
// Shared constants and helpers for the 3-share second-order masked AES S-box datapath.
// Tower field: GF(2^4) mod x^4+x+1, byte = a*W + b*Y with W+Y = 1 and W*Y = 0x8.
package g256_out_stage_2om_pkg;

   localparam int NUM_SHARES = 3;
   localparam int BYTE_W     = 8;
   localparam int NIB_W      = 4;
   localparam int RAND_W     = 12;

   localparam logic [BYTE_W-1:0] AFFINE_C = 8'h63;

   // Matrix entry i is the column hit by input bit i.
   // M_OUT = AES affine matrix * (tower -> AES basis); M_IN = (AES -> tower basis).
   localparam logic [7:0][BYTE_W-1:0] M_OUT = {8'h68, 8'h38, 8'h9C, 8'hD6,
                                               8'hEC, 8'h8A, 8'h28, 8'hC9};
   localparam logic [7:0][BYTE_W-1:0] M_IN  = {8'hE5, 8'h8D, 8'h5B, 8'h41,
                                               8'h74, 8'hFC, 8'h26, 8'h11};

   function automatic logic [NIB_W-1:0] gf16_mul(input logic [NIB_W-1:0] a,
                                                  input logic [NIB_W-1:0] b);
      logic [NIB_W-1:0] acc;
      logic [NIB_W-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < NIB_W; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
      end
      return acc;
   endfunction

   function automatic logic [BYTE_W-1:0] lin_map(input logic [7:0][BYTE_W-1:0] m,
                                                  input logic [BYTE_W-1:0] v);
      logic [BYTE_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         if (v[i]) acc = acc ^ m[i];
      end
      return acc;
   endfunction

endpackage

// File: rtl/gf16_mul_dom_2om.sv
// 3-share domain-oriented GF(2^4) multiplier: one register stage, compression after it.
module gf16_mul_dom_2om
   import g256_out_stage_2om_pkg::*;
(
   input  logic              clk,
   input  logic [NIB_W-1:0]  a1,
   input  logic [NIB_W-1:0]  a2,
   input  logic [NIB_W-1:0]  a3,
   input  logic [NIB_W-1:0]  b1,
   input  logic [NIB_W-1:0]  b2,
   input  logic [NIB_W-1:0]  b3,
   input  logic [RAND_W-1:0] r,
   output logic [NIB_W-1:0]  c1,
   output logic [NIB_W-1:0]  c2,
   output logic [NIB_W-1:0]  c3
);

   logic [NIB_W-1:0] p11, p22, p33;
   logic [NIB_W-1:0] q12, q21, q13, q31, q23, q32;

   // Each cross pair (i,j)/(j,i) shares one fresh nibble so it cancels on recombination;
   // every cone touches at most two shares before the register.
   always_ff @(posedge clk) begin
      p11 <= gf16_mul(a1, b1);
      p22 <= gf16_mul(a2, b2);
      p33 <= gf16_mul(a3, b3);
      q12 <= gf16_mul(a1, b2) ^ r[3:0];
      q21 <= gf16_mul(a2, b1) ^ r[3:0];
      q13 <= gf16_mul(a1, b3) ^ r[7:4];
      q31 <= gf16_mul(a3, b1) ^ r[7:4];
      q23 <= gf16_mul(a2, b3) ^ r[11:8];
      q32 <= gf16_mul(a3, b2) ^ r[11:8];
   end

   assign c1 = p11 ^ q12 ^ q13;
   assign c2 = p22 ^ q21 ^ q23;
   assign c3 = p33 ^ q31 ^ q32;

endmodule

// File: rtl/g256_out_stage_2om.sv
// Output stage of the masked AES S-box: aligns x with the GF(2^4) inverse, multiplies
// both nibbles per share, and maps each share back to the AES basis with the affine step.
module g256_out_stage_2om
   import g256_out_stage_2om_pkg::*;
#(
   parameter int INV_LAT = 3
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [BYTE_W-1:0]   x1,
   input  logic [BYTE_W-1:0]   x2,
   input  logic [BYTE_W-1:0]   x3,
   input  logic [NIB_W-1:0]    inv1,
   input  logic [NIB_W-1:0]    inv2,
   input  logic [NIB_W-1:0]    inv3,
   input  logic [2*RAND_W-1:0] r,
   output logic                out_valid,
   output logic [BYTE_W-1:0]   out1,
   output logic [BYTE_W-1:0]   out2,
   output logic [BYTE_W-1:0]   out3
);

   logic [BYTE_W-1:0] d1 [INV_LAT];
   logic [BYTE_W-1:0] d2 [INV_LAT];
   logic [BYTE_W-1:0] d3 [INV_LAT];
   logic [INV_LAT+1:0] vpipe;
   logic [NIB_W-1:0]  hi1, hi2, hi3, lo1, lo2, lo3;
   logic [BYTE_W-1:0] prod1, prod2, prod3;

   // Data delay is unreset; the output register only loads it when a valid token is present.
   always_ff @(posedge clk) begin
      d1[0] <= x1;
      d2[0] <= x2;
      d3[0] <= x3;
      for (int i = 1; i < INV_LAT; i++) begin
         d1[i] <= d1[i-1];
         d2[i] <= d2[i-1];
         d3[i] <= d3[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) vpipe <= '0;
      else     vpipe <= {vpipe[INV_LAT:0], in_valid};
   end

   assign out_valid = vpipe[INV_LAT+1];

   gf16_mul_dom_2om u_mul_hi (
      .clk (clk),
      .a1  (inv1), .a2 (inv2), .a3 (inv3),
      .b1  (d1[INV_LAT-1][3:0]), .b2 (d2[INV_LAT-1][3:0]), .b3 (d3[INV_LAT-1][3:0]),
      .r   (r[RAND_W-1:0]),
      .c1  (hi1), .c2 (hi2), .c3 (hi3)
   );

   gf16_mul_dom_2om u_mul_lo (
      .clk (clk),
      .a1  (inv1), .a2 (inv2), .a3 (inv3),
      .b1  (d1[INV_LAT-1][7:4]), .b2 (d2[INV_LAT-1][7:4]), .b3 (d3[INV_LAT-1][7:4]),
      .r   (r[2*RAND_W-1:RAND_W]),
      .c1  (lo1), .c2 (lo2), .c3 (lo3)
   );

   assign prod1 = {hi1, lo1};
   assign prod2 = {hi2, lo2};
   assign prod3 = {hi3, lo3};

   // Idle cycles load zero so stale multiplier contents never reach the outputs.
   always_ff @(posedge clk) begin
      if (rst || !vpipe[INV_LAT]) begin
         out1 <= '0;
         out2 <= '0;
         out3 <= '0;
      end else begin
         out1 <= lin_map(M_OUT, prod1) ^ AFFINE_C;
         out2 <= lin_map(M_OUT, prod2);
         out3 <= lin_map(M_OUT, prod3);
      end
   end

endmodule

// File: tb/tb_g256_out_stage_2om.sv
// Directed bench for g256_out_stage_2om: golden inverse feed and AES S-box reference.
module tb_g256_out_stage_2om;
   import g256_out_stage_2om_pkg::*;

   localparam int INV_LAT = 3;
   localparam int LAT     = INV_LAT + 2;
   localparam int MAXC    = 300;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  x1, x2, x3;
   logic [3:0]  inv1, inv2, inv3;
   logic [23:0] r;
   logic        out_valid;
   logic [7:0]  out1, out2, out3;

   int checks   = 0;
   int failures = 0;

   logic       stim_valid [MAXC];
   logic       stim_rst   [MAXC];
   logic [7:0] stim_byte  [MAXC];
   logic [7:0] stim_exp   [MAXC];
   logic [7:0] tower_val  [MAXC];

   g256_out_stage_2om #(.INV_LAT(INV_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x1        (x1),
      .x2        (x2),
      .x3        (x3),
      .inv1      (inv1),
      .inv2      (inv2),
      .inv3      (inv3),
      .r         (r),
      .out_valid (out_valid),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
      for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
      return p[3:0];
   endfunction

   function automatic logic [3:0] gfInv(input logic [3:0] a);
      logic [3:0] res;
      res = '0;
      for (int v = 1; v < 16; v++) if (gfMul(a, 4'(v)) == 4'h1) res = 4'(v);
      return res;
   endfunction

   // Inverse of the tower norm ab + 0x8*(a+b)^2, as the upstream inverter would deliver it
   function automatic logic [3:0] towerNormInv(input logic [7:0] t);
      logic [3:0] s;
      s = t[7:4] ^ t[3:0];
      return gfInv(gfMul(t[7:4], t[3:0]) ^ gfMul(4'h8, gfMul(s, s)));
   endfunction

   function automatic logic [7:0] aesMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] v);
      logic [7:0] s, t;
      s = '0;
      for (int c = 1; c < 256; c++) if (aesMul(v, 8'(c)) == 8'h01) s = 8'(c);
      t = s;
      for (int i = 0; i < 4; i++) begin
         s = {s[6:0], s[7]};
         t = t ^ s;
      end
      return t ^ 8'h63;
   endfunction

   function automatic logic [7:0] mapIn(input logic [7:0] v);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) if (v[i]) acc = acc ^ M_IN[i];
      return acc;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clearStim();
      for (int i = 0; i < MAXC; i++) begin
         stim_valid[i] = 1'b0;
         stim_rst[i]   = 1'b0;
         stim_byte[i]  = 8'h00;
         stim_exp[i]   = 8'h00;
      end
   endtask

   // Drives n cycles from the stimulus tables (plus a drain) and checks each output slot
   task automatic applyStimulus(input int n, input string tag);
      logic [7:0] xv, s1, s2;
      logic [3:0] iv, i1, i2;
      logic       exp_v;
      for (int k = 0; k < n + LAT; k++) begin
         @(negedge clk);
         if (k >= LAT) begin
            exp_v = stim_valid[k-LAT];
            for (int j = k - LAT; j < k; j++) if (stim_rst[j]) exp_v = 1'b0;
            checkOutput($sformatf("%s_valid[%0d]", tag, k - LAT), 32'(out_valid), 32'(exp_v));
            if (exp_v)
               checkOutput($sformatf("%s_data[%0d]", tag, k - LAT),
                           32'(out1 ^ out2 ^ out3), 32'(stim_exp[k-LAT]));
         end else begin
            checkOutput($sformatf("%s_idle[%0d]", tag, k), 32'(out_valid), 32'd0);
         end
         if (k < n) begin
            rst      = stim_rst[k];
            in_valid = stim_valid[k];
            xv       = mapIn(stim_byte[k]);
         end else begin
            rst      = 1'b0;
            in_valid = 1'b0;
            xv       = 8'($urandom);
         end
         tower_val[k] = xv;
         s1 = 8'($urandom);
         s2 = 8'($urandom);
         x1 = s1;
         x2 = s2;
         x3 = xv ^ s1 ^ s2;
         iv = (k >= INV_LAT) ? towerNormInv(tower_val[k-INV_LAT]) : 4'($urandom);
         i1 = 4'($urandom);
         i2 = 4'($urandom);
         inv1 = i1;
         inv2 = i2;
         inv3 = iv ^ i1 ^ i2;
         r    = 24'($urandom);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      x1 = 8'($urandom); x2 = 8'($urandom); x3 = 8'($urandom);
      inv1 = 4'($urandom); inv2 = 4'($urandom); inv3 = 4'($urandom);
      r = 24'($urandom);

      // Reset held with in_valid high, then idle after release
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("rst_valid", 32'(out_valid), 32'd0);
         checkOutput("rst_data", 32'({out1, out2, out3}), 32'd0);
         x1 = 8'($urandom); x2 = 8'($urandom); x3 = 8'($urandom);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < LAT; c++) begin
         @(negedge clk);
         checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
         checkOutput("post_rst_data", 32'({out1, out2, out3}), 32'd0);
      end

      clearStim();
      stim_valid[0] = 1'b1; stim_byte[0] = 8'h00; stim_exp[0] = 8'h63;
      applyStimulus(1, "zero");

      clearStim();
      for (int i = 0; i < 100; i++) begin
         stim_valid[i] = 1'b1; stim_byte[i] = 8'h53; stim_exp[i] = 8'hED;
      end
      applyStimulus(100, "known53");

      clearStim();
      for (int i = 0; i < 256; i++) begin
         stim_valid[i] = 1'b1; stim_byte[i] = 8'(i); stim_exp[i] = sbox(8'(i));
      end
      applyStimulus(256, "stream");

      clearStim();
      stim_valid[0] = 1'b1; stim_byte[0] = 8'h00; stim_exp[0] = 8'h63;
      stim_valid[1] = 1'b0; stim_byte[1] = 8'hAA;
      stim_valid[2] = 1'b1; stim_byte[2] = 8'h01; stim_exp[2] = 8'h7C;
      stim_valid[3] = 1'b1; stim_byte[3] = 8'h02; stim_exp[3] = 8'h77;
      stim_valid[4] = 1'b0; stim_byte[4] = 8'hBB;
      applyStimulus(5, "gapped");

      clearStim();
      stim_valid[0] = 1'b1; stim_byte[0] = 8'h10; stim_exp[0] = 8'hCA;
      stim_valid[1] = 1'b1; stim_byte[1] = 8'h20; stim_exp[1] = 8'hB7;
      stim_valid[2] = 1'b1; stim_byte[2] = 8'h30; stim_exp[2] = 8'h04;
      stim_valid[3] = 1'b1; stim_byte[3] = 8'h40; stim_rst[3] = 1'b1;
      stim_valid[4] = 1'b1; stim_byte[4] = 8'h01; stim_exp[4] = 8'h7C;
      applyStimulus(6, "midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
